// File: rtl/affine_inv_pkg.sv
// affine_inv_pkg
//   Shared definitions for the sequential affine inverse x = (y - b) / m.
//   Holds the controller state encoding, the width/step-count helpers
//   derived from IW/QW, and the saturation magnitudes for a W-bit result.
//   Optional feature macro: AFFINE_INV_ROUND_EN (adds one guard quotient
//   step so the result can be rounded half away from zero).
package affine_inv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Numerator width: |y - b| needs W+1 bits, then QW fraction bits are
  // appended so the quotient keeps QW fraction bits.
  function automatic int calc_n(input int iw, input int qw);
    return iw + 2 * qw + 1;
  endfunction

  // Number of restoring steps; the rounding build computes one extra
  // quotient bit below the LSB to act as the guard bit.
  function automatic int calc_steps(input int iw, input int qw);
`ifdef AFFINE_INV_ROUND_EN
    return calc_n(iw, qw) + 1;
`else
    return calc_n(iw, qw);
`endif
  endfunction

  // Largest positive magnitude representable in a signed w-bit word.
  function automatic logic [63:0] sat_pos_mag(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Largest negative magnitude representable in a signed w-bit word.
  function automatic logic [63:0] sat_neg_mag(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/affine_inv1d_seq_udiv_step.sv
// udiv_step
//   One combinational restoring-division step.
//   Ports:
//     rem_in   - partial remainder from the previous step (always < div_in)
//     num_bit  - next numerator bit, MSB first
//     div_in   - unsigned divisor
//     rem_out  - updated partial remainder
//     q_bit    - quotient bit produced by this step
module udiv_step #(
  parameter int RW = 17,
  parameter int DW = 17
) (
  input  logic [RW-1:0] rem_in,
  input  logic          num_bit,
  input  logic [DW-1:0] div_in,
  output logic [RW-1:0] rem_out,
  output logic          q_bit
);

  logic [RW:0] trial;
  logic [RW:0] div_ext;

  always_comb begin
    trial   = {rem_in, num_bit};
    div_ext = (RW + 1)'(div_in);
    rem_out = RW'(trial);
    q_bit   = 1'b0;
    // The remainder entering a step is below the divisor, so after the
    // subtraction it fits back into RW bits.
    if (trial >= div_ext) begin
      rem_out = RW'(trial - div_ext);
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/affine_inv1d_seq.sv
// affine_inv1d_seq
//   Sequential inverse of the fixed-point multiply-accumulate:
//   x = (y - b) / m in signed Q(IW).(QW), one quotient bit per cycle.
//   Optional feature macro: AFFINE_INV_ROUND_EN (round half away from zero
//   instead of truncation toward zero; latency grows by one cycle).
//   Ports:
//     clk_in, rst_n_in      - clock, asynchronous active-low reset
//     in_valid / in_ready   - operand handshake (y_in, m_in, b_in)
//     out_valid / out_ready - result handshake (x_out, sat_out, div0_out)
//     sat_out               - result was clamped to the W-bit range
//     div0_out              - m was zero
module affine_inv1d_seq
  import affine_inv_pkg::*;
#(
  parameter int IW = 8,
  parameter int QW = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW+QW-1:0] y_in,
  input  logic [IW+QW-1:0] m_in,
  input  logic [IW+QW-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW+QW-1:0] x_out,
  output logic             sat_out,
  output logic             div0_out
);

  localparam int W     = IW + QW;
  localparam int N     = calc_n(IW, QW);
  localparam int STEPS = calc_steps(IW, QW);
  localparam int RW    = W + 1;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [63:0]      POS_LIM64 = sat_pos_mag(W);
  localparam logic [63:0]      NEG_LIM64 = sat_neg_mag(W);
  localparam logic [STEPS-1:0] POS_LIM   = POS_LIM64[STEPS-1:0];
  localparam logic [STEPS-1:0] NEG_LIM   = NEG_LIM64[STEPS-1:0];
  localparam logic [W-1:0]     POS_WORD  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     NEG_WORD  = {1'b1, {(W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [N-1:0]     num_q, num_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [W:0]       div_q, div_d;
  logic [STEPS-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [W-1:0]     x_q, x_d;
  logic             sat_q, sat_d;
  logic             div0_q, div0_d;

  logic [W:0]       d_wide;
  logic [W:0]       d_abs;
  logic [W:0]       m_ext;
  logic [W:0]       m_abs;
  logic [STEPS-1:0] mag;
  logic [RW-1:0]    step_rem;
  logic             step_q;

  udiv_step #(
    .RW (RW),
    .DW (W + 1)
  ) u_step (
    .rem_in  (rem_q),
    .num_bit (num_q[N-1]),
    .div_in  (div_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    // One extra bit keeps y - b exact for any pair of W-bit operands.
    d_wide = {y_in[W-1], y_in} - {b_in[W-1], b_in};
    d_abs  = d_wide[W] ? -d_wide : d_wide;
    m_ext  = {m_in[W-1], m_in};
    m_abs  = m_in[W-1] ? -m_ext : m_ext;

`ifdef AFFINE_INV_ROUND_EN
    // Drop the guard bit and add it back: half away from zero on magnitude.
    mag = {1'b0, quo_q[STEPS-1:1]} + {{(STEPS-1){1'b0}}, quo_q[0]};
`else
    mag = quo_q;
`endif

    state_d = state_q;
    num_d   = num_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    x_d     = x_q;
    sat_d   = sat_q;
    div0_d  = div0_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = d_wide[W] ^ m_in[W-1];
          num_d  = {d_abs, {QW{1'b0}}};
          div_d  = m_abs;
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = '0;
          sat_d  = 1'b0;
          div0_d = 1'b0;
          if (m_in == '0) begin
            div0_d  = 1'b1;
            state_d = DONE;
            if (d_wide == '0) begin
              x_d = '0;
            end else if (d_wide[W]) begin
              x_d   = NEG_WORD;
              sat_d = 1'b1;
            end else begin
              x_d   = POS_WORD;
              sat_d = 1'b1;
            end
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Numerator shifts out MSB first; zeros follow once it is consumed,
        // which is what the optional guard step needs.
        rem_d = step_rem;
        quo_d = {quo_q[STEPS-2:0], step_q};
        num_d = {num_q[N-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (!sign_q && (mag > POS_LIM)) begin
          x_d   = POS_WORD;
          sat_d = 1'b1;
        end else if (sign_q && (mag > NEG_LIM)) begin
          x_d   = NEG_WORD;
          sat_d = 1'b1;
        end else if (sign_q) begin
          x_d = -mag[W-1:0];
        end else begin
          x_d = mag[W-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      num_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      x_q     <= '0;
      sat_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      x_q     <= x_d;
      sat_q   <= sat_d;
      div0_q  <= div0_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign x_out     = x_q;
  assign sat_out   = sat_q;
  assign div0_out  = div0_q;

endmodule

// File: tb/tb_affine_inv1d_seq.sv
// tb_affine_inv1d_seq
//   Directed bench for affine_inv1d_seq (IW=QW=8). Expected results are
//   queued when a job is accepted and compared when out_valid rises.
module tb_affine_inv1d_seq;

`ifdef AFFINE_INV_ROUND_EN
  localparam int           LAT       = 27;
  localparam logic [15:0]  X_THIRD   = 16'h00AB;
  localparam logic [15:0]  X_NTHIRD  = 16'hFF55;
`else
  localparam int           LAT       = 26;
  localparam logic [15:0]  X_THIRD   = 16'h00AA;
  localparam logic [15:0]  X_NTHIRD  = 16'hFF56;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] y_in = '0;
  logic [15:0] m_in = '0;
  logic [15:0] b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] x_out;
  logic        sat_out;
  logic        div0_out;

  typedef struct {
    string       tag;
    logic [15:0] x;
    logic        sat;
    logic        div0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  affine_inv1d_seq #(.IW(8), .QW(8)) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .m_in      (m_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .sat_out   (sat_out),
    .div0_out  (div0_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one job and queue its expected result at the accepting edge.
  task automatic apply_stimulus(input string tag, input logic [15:0] y, input logic [15:0] m,
                                input logic [15:0] b, input logic [15:0] ex, input logic es,
                                input logic ed, input int lat);
    @(negedge clk);
    check({tag, " in_ready_before"}, {31'd0, in_ready}, 32'd1);
    y_in = y;
    m_in = m;
    b_in = b;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{tag, ex, es, ed, lat});
    #1 in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then pop and compare the oldest entry.
  task automatic check_output();
    exp_t e;
    int   k = 0;
    while (k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 1) check("busy_in_ready", {31'd0, in_ready}, 32'd0);
      if (out_valid) break;
    end
    check("sb_size", sb.size(), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({e.tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    if (!out_valid) return;
    check({e.tag, " latency"}, k, e.lat);
    check({e.tag, " x"}, {16'd0, x_out}, {16'd0, e.x});
    check({e.tag, " sat"}, {31'd0, sat_out}, {31'd0, e.sat});
    check({e.tag, " div0"}, {31'd0, div0_out}, {31'd0, e.div0});
  endtask

  task automatic finish_output();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] held_x;

    #12;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset x", {16'd0, x_out}, 32'd0);
    check("reset sat", {31'd0, sat_out}, 32'd0);
    check("reset div0", {31'd0, div0_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("basic", 16'h0300, 16'h0080, 16'h0100, 16'h0400, 1'b0, 1'b0, LAT);
    check_output(); finish_output();
    apply_stimulus("neg", 16'hFF00, 16'h0180, 16'h0080, 16'hFF00, 1'b0, 1'b0, LAT);
    check_output(); finish_output();
    apply_stimulus("div0_pos", 16'h0100, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1, 1);
    check_output(); finish_output();
    apply_stimulus("div0_zero", 16'h0250, 16'h0000, 16'h0250, 16'h0000, 1'b0, 1'b1, 1);
    check_output(); finish_output();
    apply_stimulus("div0_neg", 16'h8000, 16'h0000, 16'h0100, 16'h8000, 1'b1, 1'b1, 1);
    check_output(); finish_output();
    apply_stimulus("sat_pos", 16'h6400, 16'h0040, 16'h0000, 16'h7FFF, 1'b1, 1'b0, LAT);
    check_output(); finish_output();
    apply_stimulus("sat_neg", 16'h6400, 16'hFFC0, 16'h0000, 16'h8000, 1'b1, 1'b0, LAT);
    check_output(); finish_output();
    apply_stimulus("third", 16'h0200, 16'h0300, 16'h0000, X_THIRD, 1'b0, 1'b0, LAT);
    check_output(); finish_output();
    apply_stimulus("nthird", 16'hFE00, 16'h0300, 16'h0000, X_NTHIRD, 1'b0, 1'b0, LAT);
    check_output(); finish_output();
    apply_stimulus("neg_edge", 16'h8000, 16'h0100, 16'h0000, 16'h8000, 1'b0, 1'b0, LAT);
    check_output(); finish_output();
    apply_stimulus("wide_d", 16'h7FFF, 16'h0100, 16'h8000, 16'h7FFF, 1'b1, 1'b0, LAT);
    check_output(); finish_output();

    // Stall in DONE with the next job already presented.
    apply_stimulus("stall1", 16'h0300, 16'h0080, 16'h0100, 16'h0400, 1'b0, 1'b0, LAT);
    check_output();
    held_x = x_out;
    y_in = 16'hFF00;
    m_in = 16'h0180;
    b_in = 16'h0080;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall x", {16'd0, x_out}, {16'd0, held_x});
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_hs out_valid", {31'd0, out_valid}, 32'd0);
    check("stall_hs in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    sb.push_back('{"stall2", 16'hFF00, 1'b0, 1'b0, LAT});
    #1 in_valid = 1'b0;
    check_output(); finish_output();

    // Reset in the middle of a calculation abandons the job.
    apply_stimulus("aborted", 16'h0300, 16'h0080, 16'h0100, 16'h0400, 1'b0, 1'b0, LAT);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete(0);
    #2;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    check("abort x", {16'd0, x_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort no_output", {31'd0, out_valid}, 32'd0);
    apply_stimulus("after_abort", 16'h0200, 16'h0300, 16'h0000, X_THIRD, 1'b0, 1'b0, LAT);
    check_output(); finish_output();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/affine_inv1d_seq.md
# affine_inv1d_seq

Sequential inverse of the fixed-point multiply-accumulate: given y, m and b, computes x = (y − b) / m in signed fixed point with a restoring divider, one quotient bit per cycle. It sits after the macc stage wherever a layer output must be mapped back to its input domain, for example de-normalisation or inverse gain. A valid/ready handshake on both sides lets it sit inside streaming pipelines.

## Interface
- IW, 8: integer bits including sign; shared by y, m, b and x.
- QW, 8: fraction bits; shared by all operands.
- W (derived), IW+QW: word width.
- Clocking: one clock; reset is asynchronous and active-low.
- clk_in  input  1  clock.
- rst_n_in  input  1  async active-low reset.
- in_valid  input  1  y, m, b valid.
- in_ready  output  1  block can accept operands.
- y_in, m_in, b_in  input  W each  signed fixed-point operands.
- out_valid  output  1  x_out and flags valid.
- out_ready  input  1  downstream accepts result.
- x_out  output  W  signed fixed-point quotient.
- sat_out  output  1  result was clamped.
- div0_out  output  1  m was zero.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - register d = y − b at W+1 bits, exact with no wrap;
  - register sign = sign(d) XOR sign(m);
  - register numerator magnitude |d|<<QW, width N = W+QW+1;
  - register divisor |m| at W+1 bits;
  - clear the counter.
- m==0 at accept: go directly to DONE with div0_out=1, sat_out=1 and x_out set as follows.
  - d>0: x_out = 0x7FF…F.
  - d<0: x_out = 0x800…0.
  - d==0: x_out = 0, sat_out=0.
- CALC: one restoring step per cycle, MSB first:
  - shift remainder left by 1 and bring in the next numerator bit;
  - if remainder ≥ |m|, subtract |m| and set the quotient bit to 1.
  - N steps, then go to FIX.
- FIX: apply the sign; rounding is toward zero.
  - Positive magnitude > 2^(W−1)−1: clamp to 0x7FF…F, sat_out=1.
  - Negative magnitude > 2^(W−1): clamp to 0x800…0, sat_out=1.
  - Register x_out, then go to DONE.
- DONE: out_valid=1. x_out and the flags stay stable until out_ready; the handshake returns the state to IDLE.
- in_ready is low in CALC, FIX and DONE. There is no overlap of jobs.
- Reset values: state IDLE, in_ready=1 (reset is low) after release, out_valid=0, x_out=0, sat_out=0, div0_out=0.
- Reset mid-operation aborts the job with no output. The next accept starts clean.
- An in_valid held during DONE is not accepted until the cycle after the output handshake.

## Timing
- Accept at clock edge A. CALC occupies edges A+1…A+N, FIX updates at A+N+1, out_valid is high from edge A+N+1.
- Latency L = N+1 cycles. For IW=QW=8: N=25, L=26.
- Div-by-zero: out_valid is high one cycle after accept.
- Output handshake at edge H: out_valid=0 and in_ready=1 after H. Next accept is no earlier than H+1.
- Throughput: one result per L+2 cycles with zero stall.

## Configuration
- AFFINE_INV_ROUND_EN defined:
  - CALC runs N+1 steps, producing one guard quotient bit.
  - FIX adds the guard bit to the magnitude, giving round half away from zero, before sign and saturation.
  - L = N+2.
- Undefined: truncation toward zero, L = N+1.
- The div-by-zero path is identical in both builds.

## Structure
- Package affine_inv_pkg holds:
  - the state enum {IDLE, CALC, FIX, DONE};
  - the N and step-count localparam functions of IW/QW;
  - the saturation constants.
- Sub-module udiv_step: combinational single restoring step with remainder in, numerator bit and divisor in; remainder out, quotient bit out.

## Test plan
- IW=QW=8; y=0x0300 (3.0), b=0x0100, m=0x0080 (0.5) -> x=0x0400 (4.0), sat=0, div0=0, out_valid exactly 26 cycles after accept.
- y=0xFF00 (−1.0), b=0x0080 (0.5), m=0x0180 (1.5) -> x=0xFF00 (−1.0).
- m=0 cases:
  - y=0x0100, b=0 -> x=0x7FFF, div0=1, sat=1, one-cycle latency;
  - y=b -> x=0, div0=1, sat=0.
- y=0x6400 (100.0), b=0, m=0x0040 (0.25) -> x=0x7FFF, sat=1. The same with m=0xFFC0 (−0.25) -> x=0x8000, sat=1.
- y=0x0200 (2.0), b=0, m=0x0300 (3.0) -> x=0x00AA without the macro, 0x00AB with AFFINE_INV_ROUND_EN.
- Hold out_ready=0 for 10 cycles in DONE -> x_out stable and in_ready=0 throughout. Pulse rst_n_in low mid-CALC -> out_valid=0, next job correct.
